instr_mem_loader: RTL

//  Writer side of the 16-entry instruction memory.

---
 rtl/instr_mem_loader_if.sv | 42 ++++
 rtl/instr_mem_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream loader bus: host byte handshake plus instruction-memory write port.
// Latency: n/a (signal bundle only).
// Backpressure: byteReady from the loader throttles the host byte stream.
//
// Signals:
//   start      host -> loader  1-cycle pulse, begin/restart a load at address 0
//   byteIn     host -> loader  stream byte
//   byteValid  host -> loader  byteIn valid
//   byteReady  loader -> host  loader accepts a byte this cycle
//   wrEn       loader -> mem   1-cycle write strobe
//   wrAddr     loader -> mem   write address
//   wrData     loader -> mem   assembled instruction word
//   busy       loader -> host  load in progress
//   done       loader -> host  all words written, held until next start
//   chkErr     loader -> host  checksum mismatch (checksum build only)
interface instr_mem_loader_if #(
  parameter int TAM    = 32,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [TAM-1:0]    wrData;
  logic              busy;
  logic              done;
  logic              chkErr;

  // host / testbench side
  modport master (
    output start, byteIn, byteValid,
    input  byteReady, wrEn, wrAddr, wrData, busy, done, chkErr
  );

  // loader side
  modport slave (
    input  start, byteIn, byteValid,
    output byteReady, wrEn, wrAddr, wrData, busy, done, chkErr
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a byte stream (MSB first) into tam-bit words, writes DEPTH words to addr 0..DEPTH-1.
// Latency: wrEn one cycle after the last byte of a word is accepted; tam/8+1 cycles/word peak.
// Backpressure: byteReady low outside COLLECT (and CHECK); byteValid gaps only stall COLLECT.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instr_mem_loader_if.slave (start, byte handshake, write port, status)
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and chkErr.
// tam must be a multiple of 8 and at least 16.
module instr_mem_loader #(
  parameter int tam    = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_mem_loader_if.slave     bus
);

  localparam int NB    = tam / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [tam-1:0]    shift_q;
  logic [tam-1:0]    wr_data_q;
  logic [tam-1:0]    word_nxt;
  logic              byte_rdy;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic              accept;
  logic              last_byte;
  logic              last_addr;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
  logic              chk_err_q;
`endif

  assign word_nxt  = {shift_q[tam-9:0], bus.byteIn};
  assign last_byte = (cnt_q == CNT_W'(NB - 1));
  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
  // start takes priority over a coincident byte: the byte is dropped
  assign accept    = bus.byteValid & byte_rdy & ~bus.start;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      // start from any state (including mid-load) restarts at address 0
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: if (accept && last_byte) state_d = S_WRITE;
        S_WRITE: begin
          if (last_addr) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_COLLECT;
          end
        end
        S_DONE:    state_d = S_DONE;
`ifdef LOADER_CHECKSUM_EN
        S_CHECK:   if (accept) state_d = S_DONE;
`endif
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    byte_rdy = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_COLLECT: begin
        byte_rdy = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        busy  = 1'b1;
        // an abort landing on the write cycle suppresses the write
        wr_en = ~bus.start;
      end
      S_DONE: done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_rdy = 1'b1;
        busy     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      shift_q   <= '0;
      wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else if (bus.start) begin
      // partial word discarded; wr_addr_q/wr_data_q keep their last value
      cnt_q     <= '0;
      addr_q    <= '0;
      shift_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      if (state_q == S_COLLECT && accept) begin
        shift_q <= word_nxt;
`ifdef LOADER_CHECKSUM_EN
        xor_q   <= xor_q ^ bus.byteIn;
`endif
        if (last_byte) begin
          cnt_q     <= '0;
          wr_data_q <= word_nxt;
          wr_addr_q <= addr_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      // address saturates at the last word so it never wraps within a load
      if (state_q == S_WRITE && !last_addr) addr_q <= addr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (state_q == S_CHECK && accept) chk_err_q <= (bus.byteIn != xor_q);
`endif
    end
  end

  assign bus.byteReady = byte_rdy;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.wrEn      = wr_en;
  assign bus.wrAddr    = wr_addr_q;
  assign bus.wrData    = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.chkErr    = chk_err_q;
`else
  assign bus.chkErr    = 1'b0;
`endif

endmodule
